// File: rtl/pc_branch_unit.sv
// Per-thread program-counter and condition-flag unit.
// Resolves next_pc during EXECUTE (SEQ/BR/JMP/CALL/RET) and latches the NZP
// flags during UPDATE. CALL/RET use a small non-wrapping LIFO of return
// addresses with sticky overflow/underflow indicators.
module pc_branch_unit #(
  parameter int PC_WIDTH      = 8,
  parameter int STACK_DEPTH   = 4,
  parameter int NZP_MASK_MODE = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [2:0]                         core_state,
  input  logic [2:0]                         branch_op,
  input  logic [2:0]                         nzp_instr,
  input  logic [2:0]                         nzp_in,
  input  logic                               nzp_write_enable,
  input  logic [PC_WIDTH-1:0]                current_pc,
  input  logic [PC_WIDTH-1:0]                target,
  output logic [2:0]                         nzp,
  output logic [PC_WIDTH-1:0]                next_pc,
  output logic                               branch_taken,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SLOTS   = 1 << IDX_W;
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

  localparam logic [2:0] ST_EXECUTE = 3'b101;
  localparam logic [2:0] ST_UPDATE  = 3'b110;

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;

  // Sequential successor; wraps naturally at PC_WIDTH bits.
  function automatic logic [PC_WIDTH-1:0] inc_pc(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(1);
  endfunction

  // Branch condition: any-bit overlap (mask mode) or exact flag match.
  function automatic logic br_match(input logic [2:0] cond, input logic [2:0] flags);
    if (NZP_MASK_MODE != 0) return |(cond & flags);
    else                    return cond == flags;
  endfunction

  logic [PC_WIDTH-1:0] ret_stack [SLOTS];

  logic                exec_p0;
  logic                upd_p0;
  logic                stack_full_p0;
  logic                stack_empty_p0;
  logic [PC_WIDTH-1:0] seq_pc_p0;
  logic [IDX_W-1:0]    push_idx_p0;
  logic [IDX_W-1:0]    pop_idx_p0;
  logic [PC_WIDTH-1:0] nxt_pc_p0;
  logic                nxt_taken_p0;
  logic [DEPTH_W-1:0]  nxt_depth_p0;
  logic                push_p0;
  logic                set_ovf_p0;
  logic                set_unf_p0;

  // Stage p0: decode the operation and resolve the next PC and stack action.
  always_comb begin
    exec_p0        = enable && (core_state == ST_EXECUTE);
    upd_p0         = enable && (core_state == ST_UPDATE) && nzp_write_enable;
    stack_full_p0  = (stack_depth == DEPTH_FULL);
    stack_empty_p0 = (stack_depth == '0);
    seq_pc_p0      = inc_pc(current_pc);
    push_idx_p0    = IDX_W'(stack_depth);
    pop_idx_p0     = IDX_W'(stack_depth - DEPTH_W'(1));
    nxt_pc_p0      = next_pc;
    nxt_taken_p0   = 1'b0;
    nxt_depth_p0   = stack_depth;
    push_p0        = 1'b0;
    set_ovf_p0     = 1'b0;
    set_unf_p0     = 1'b0;
    if (exec_p0) begin
      nxt_pc_p0 = seq_pc_p0;
      case (branch_op)
        OP_BR: begin
          if (br_match(nzp_instr, nzp)) begin
            nxt_pc_p0    = target;
            nxt_taken_p0 = 1'b1;
          end
        end
        OP_JMP: begin
          nxt_pc_p0    = target;
          nxt_taken_p0 = 1'b1;
        end
        OP_CALL: begin
          if (stack_full_p0) begin
            set_ovf_p0 = 1'b1;
          end else begin
            push_p0      = 1'b1;
            nxt_depth_p0 = stack_depth + DEPTH_W'(1);
            nxt_pc_p0    = target;
            nxt_taken_p0 = 1'b1;
          end
        end
        OP_RET: begin
          if (stack_empty_p0) begin
            set_unf_p0 = 1'b1;
          end else begin
            nxt_depth_p0 = stack_depth - DEPTH_W'(1);
            nxt_pc_p0    = ret_stack[pop_idx_p0];
            nxt_taken_p0 = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p1: commit PC, flags, stack pointer and sticky errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      nzp             <= 3'b000;
      next_pc         <= '0;
      branch_taken    <= 1'b0;
      stack_depth     <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      branch_taken <= nxt_taken_p0;
      next_pc      <= nxt_pc_p0;
      stack_depth  <= nxt_depth_p0;
      if (upd_p0)     nzp             <= nzp_in;
      if (set_ovf_p0) stack_overflow  <= 1'b1;
      if (set_unf_p0) stack_underflow <= 1'b1;
    end
  end

  // Stage p1: return-address storage; contents need no reset.
  always_ff @(posedge clock) begin
    if (push_p0 && !reset) ret_stack[push_idx_p0] <= seq_pc_p0;
  end

endmodule
